// File: rtl/avl_apb_pkg.sv
// Shared types and helpers for the round-robin APB requester.
// rr_select works on a fixed-width request vector so any NUM_REQ up to RR_MAX can use it.
package avl_apb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

   typedef logic [2:0] apb_prot_t;

   localparam logic DECODE_ERR = 1'b1;
   localparam int   RR_MAX     = 32;

   // First set bit at or after ptr, wrapping at n; -1 when nothing is set.
   function automatic int rr_select(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
      int sel;
      int j;
      sel = -1;
      for (int k = 0; k < RR_MAX; k++) begin
         if (k < n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (sel < 0 && valid[j[4:0]]) sel = j;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/avl_apb_rr_arbiter.sv
// Combinational round-robin pick: request vector + priority pointer -> one-hot grant and index.
module avl_apb_rr_arbiter
   import avl_apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [RR_MAX-1:0] req_ext;
   int                sel;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
      sel                  = rr_select(req_ext, int'(ptr), NUM_REQ);
      any                  = (sel >= 0);
      idx                  = any ? IDX_W'(sel) : '0;
      grant                = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant[i] = any && (sel == i);
   end

endmodule

// File: rtl/avl_apb_rr_requester.sv
// Round-robin shares one APB4 requester port between NUM_REQ local requesters,
// with address-based PSEL decode and a PREADY timeout.
module avl_apb_rr_requester
   import avl_apb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int PSEL_WIDTH     = 1,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           pclk,
   input  logic                           preset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
   input  logic [NUM_REQ*3-1:0]           req_prot,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic                           rsp_err,
   output logic [ADDR_WIDTH-1:0]          paddr,
   output logic [2:0]                     pprot,
   output logic                           pwrite,
   output logic [DATA_WIDTH-1:0]          pwdata,
   output logic [DATA_WIDTH/8-1:0]        pstrb,
   output logic [PSEL_WIDTH-1:0]          psel,
   output logic                           penable,
   input  logic                           pready,
   input  logic [DATA_WIDTH-1:0]          prdata,
   input  logic                           pslverr
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SEL_W  = (PSEL_WIDTH > 1) ? $clog2(PSEL_WIDTH) : 1;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int STRB_W = DATA_WIDTH / 8;

   apb_state_e              state, state_nxt;
   logic [IDX_W-1:0]        ptr, win_idx;
   logic [NUM_REQ-1:0]      win_grant, owner;
   logic                    win_any, accept, done, timeout;
   logic [CNT_W-1:0]        cnt;

   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;
   logic [STRB_W-1:0]       win_strb;
   apb_prot_t               win_prot;
   logic                    win_write;
   logic [SEL_W-1:0]        dec_idx;
   logic                    dec_err;
   logic [PSEL_WIDTH-1:0]   psel_dec;

   avl_apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (win_grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // One-hot grant, so an AND-OR mux picks the winner's fields.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_strb  = '0;
      win_prot  = '0;
      win_write = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_grant[i]) begin
            win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            win_strb  = req_strb[i*STRB_W +: STRB_W];
            win_prot  = req_prot[i*3 +: 3];
            win_write = req_write[i];
         end
      end
   end

   if (PSEL_WIDTH > 1) begin : g_dec
      assign dec_idx = win_addr[SEL_LSB +: SEL_W];
   end else begin : g_nodec
      assign dec_idx = '0;
   end

   assign dec_err = (int'(dec_idx) >= PSEL_WIDTH);

   always_comb begin
      psel_dec = '0;
      for (int i = 0; i < PSEL_WIDTH; i++)
         psel_dec[i] = (int'(dec_idx) == i);
   end

   assign req_ready = (state == IDLE && !preset) ? win_grant : '0;
   assign accept    = (state == IDLE) && win_any;
   assign timeout   = (TIMEOUT_CYCLES != 0) && (int'(cnt) == TIMEOUT_CYCLES - 1);
   assign done      = (state == ACCESS) && (pready || timeout);

   // Decode errors never leave IDLE; their response is issued straight from the accept cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !dec_err) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         paddr     <= '0;
         pprot     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;

         if (accept) begin
            ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            owner <= win_grant;
            if (dec_err) begin
               rsp_valid <= win_grant;
               rsp_err   <= DECODE_ERR;
            end else begin
               paddr  <= win_addr;
               pprot  <= win_prot;
               pwrite <= win_write;
               pwdata <= win_write ? win_wdata : '0;
               pstrb  <= win_write ? win_strb : '0;
               psel   <= psel_dec;
            end
         end

         case (state)
            SETUP: begin
               penable <= 1'b1;
               cnt     <= '0;
            end
            ACCESS: begin
               if (cnt != '1) cnt <= cnt + 1'b1;
               if (done) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= owner;
                  rsp_err   <= pready ? pslverr : 1'b1;
                  rsp_rdata <= (pready && !pwrite) ? prdata : '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_avl_apb_rr_requester.sv
// Bench for avl_apb_rr_requester: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_avl_apb_rr_requester;

   localparam int NR = 4, PW = 3, AW = 32, DW = 32, SL = 12, TO = 8;

   logic              pclk = 1'b0;
   logic              preset;
   logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR*4-1:0]   req_strb;
   logic [NR*3-1:0]   req_prot;
   logic [DW-1:0]     rsp_rdata, pwdata, prdata;
   logic              rsp_err, pwrite, penable, pready, pslverr;
   logic [AW-1:0]     paddr;
   logic [2:0]        pprot;
   logic [3:0]        pstrb;
   logic [PW-1:0]     psel;

   always #5 pclk = ~pclk;

   avl_apb_rr_requester #(
      .NUM_REQ(NR), .PSEL_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SEL_LSB(SL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk(pclk), .preset(preset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .psel(psel), .penable(penable),
      .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NR; g++) begin : g_sva
      a_hold: assert property (@(posedge pclk) disable iff (preset)
                               (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
   end

   // stimulus knobs
   int            rate   = 0;   // % chance per cycle an idle requester raises a request
   int            wait_n = 0;   // ACCESS cycles before pready; <0 = random completer
   bit            use_fix = 0;
   logic [DW-1:0] fix_rdata = '0;
   int            acc_cnt = 0;
   logic [NR-1:0] acc = '0;
   int            grant_q[$];

   // reference model: one outstanding transfer, tracked by its age in cycles since accept
   bit            m_busy = 0;
   int            m_age = 0, m_ptr = 0, m_win = 0, m_idx = 0;
   logic          m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [3:0]    m_strb;
   logic [2:0]    m_prot;
   logic [NR-1:0] e_rv = '0;
   logic          e_err = 1'b0;
   logic [DW-1:0] e_rd = '0;

   always @(negedge pclk) begin : cmp
      int w;
      int sel;
      if (preset) begin
         chk("reset_ctl", {req_ready, rsp_valid, psel, penable, pwrite, rsp_err}, 64'd0);
         chk("reset_bus", {paddr, pwdata}, 64'd0);
         chk("reset_misc", {rsp_rdata, pstrb, pprot}, 64'd0);
         m_busy = 0; m_ptr = 0; e_rv = '0; acc = '0;
      end else begin
         w = -1;
         if (!m_busy)
            for (int k = 0; k < NR; k++)
               if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
         chk("req_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
         chk("psel", psel, m_busy ? (64'd1 << m_idx) : 64'd0);
         chk("penable", penable, 64'(m_busy && m_age >= 2));
         if (m_busy) begin
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_write);
            chk("pwdata", pwdata, m_write ? m_wdata : 32'd0);
            chk("pstrb", pstrb, m_write ? m_strb : 4'd0);
            chk("pprot", pprot, m_prot);
         end
         chk("rsp_valid", rsp_valid, e_rv);
         if (e_rv != 0) begin
            chk("rsp_err", rsp_err, e_err);
            chk("rsp_rdata", rsp_rdata, e_rd);
         end

         acc = req_valid & req_ready;
         for (int k = 0; k < NR; k++) if (acc[k]) grant_q.push_back(k);

         e_rv = '0;
         if (m_busy) begin
            if (m_age >= 2 && (pready || (m_age - 2) == TO - 1)) begin
               e_rv   = 4'(1 << m_win);
               e_err  = pready ? pslverr : 1'b1;
               e_rd   = (pready && !m_write) ? prdata : 32'd0;
               m_busy = 0;
            end else begin
               m_age++;
            end
         end else if (w >= 0) begin
            m_ptr = (w + 1) % NR;
            sel   = int'((req_addr[w*AW +: AW] >> SL) & 32'd3);
            if (sel >= PW) begin
               e_rv  = 4'(1 << w);
               e_err = 1'b1;
               e_rd  = '0;
            end else begin
               m_busy  = 1; m_age = 1; m_win = w; m_idx = sel;
               m_addr  = req_addr[w*AW +: AW];
               m_write = req_write[w];
               m_wdata = req_wdata[w*DW +: DW];
               m_strb  = req_strb[w*4 +: 4];
               m_prot  = req_prot[w*3 +: 3];
            end
         end
      end
   end

   task automatic drive_reqs();
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && ($urandom_range(99) < rate)) begin
            req_valid[i]            = 1'b1;
            req_write[i]            = 1'($urandom_range(1));
            req_addr[i*AW +: AW]    = {16'h0, 2'b00, 2'($urandom_range(3)), 10'($urandom_range(1023)), 2'b00};
            req_wdata[i*DW +: DW]   = $urandom;
            req_strb[i*4 +: 4]      = 4'($urandom_range(15));
            req_prot[i*3 +: 3]      = 3'($urandom_range(7));
         end
      end
   endtask

   task automatic drive_cpl();
      if (penable) acc_cnt++; else acc_cnt = 0;
      if (wait_n < 0) begin
         pready  = ($urandom_range(2) == 0);
         pslverr = 1'($urandom_range(1));
      end else begin
         pready  = penable && (acc_cnt > wait_n);
         pslverr = 1'b0;
      end
      prdata = use_fix ? fix_rdata : $urandom;
   endtask

   task automatic tick();
      @(posedge pclk); #1;
      drive_reqs();
      drive_cpl();
   endtask

   task automatic samp();
      @(negedge pclk); #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_strb[i*4 +: 4]    = 4'hF;
      req_prot[i*3 +: 3]    = 3'd2;
   endtask

   // Follows one transfer from its accept cycle until rsp_valid (left sampled on return).
   task automatic watch(output int cyc, output int pen, output int pseen, output bit got);
      cyc = -1; pen = 0; pseen = 0; got = 0;
      for (int c = 0; c < 40; c++) begin
         samp();
         if (rsp_valid != 0) begin
            got = 1; cyc = c;
            break;
         end
         if (penable) pen++;
         if (psel != 0) pseen++;
         tick();
      end
   endtask

   task automatic drain();
      rate = 0; wait_n = 0;
      for (int c = 0; c < 200 && (req_valid != 0 || m_busy); c++) tick();
      repeat (3) tick();
   endtask

   initial begin
      int cyc, pen, pseen;
      bit got;
      preset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      repeat (3) @(posedge pclk);
      samp();
      chk("rst_psel_penable", {psel, penable}, 64'd0);
      chk("rst_rsp_valid", rsp_valid, 64'd0);
      @(posedge pclk); #2 preset = 1'b0;

      // round robin with every requester pending
      rate = 100; wait_n = 0;
      grant_q.delete();
      for (int c = 0; c < 40 && grant_q.size() < 5; c++) tick();
      chk("rr_grants_seen", 64'(grant_q.size() >= 5), 64'd1);
      for (int k = 0; k < 5 && k < grant_q.size(); k++) chk("rr_order", grant_q[k], k % 4);
      drain();

      // single write, zero wait states
      tick();
      set_req(2, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5);
      samp(); chk("wr_ready_c0", req_ready, 4'b0100);
      tick(); samp(); chk("wr_setup_c1", {psel, penable}, {3'b010, 1'b0});
      tick(); samp(); chk("wr_access_c2", {psel, penable}, {3'b010, 1'b1});
      chk("wr_pwdata", pwdata, 32'hA5A5_A5A5);
      tick(); samp(); chk("wr_rsp_c3", {rsp_valid, rsp_err}, {4'b0100, 1'b0});
      drain();

      // read with five wait states
      wait_n = 5; use_fix = 1; fix_rdata = 32'hDEAD_BEEF;
      tick();
      set_req(1, 1'b0, 32'h0000_2008, 32'h1234_5678);
      watch(cyc, pen, pseen, got);
      chk("ws_done", got, 1);
      chk("ws_penable_cycles", pen, 6);
      chk("ws_rsp", {rsp_valid, rsp_err}, {4'b0010, 1'b0});
      chk("ws_rdata", rsp_rdata, 32'hDEAD_BEEF);
      drain();

      // timeout: completer never ready
      wait_n = 1000;
      tick();
      set_req(3, 1'b0, 32'h0000_0010, 32'h0);
      watch(cyc, pen, pseen, got);
      chk("to_done", got, 1);
      chk("to_penable_cycles", pen, TO);
      chk("to_rsp", {rsp_valid, rsp_err}, {4'b1000, 1'b1});
      chk("to_rdata", rsp_rdata, 32'h0);
      chk("to_psel_dropped", {psel, penable}, 64'd0);
      drain();
      use_fix = 0;

      // decode error: index 3 with three completers
      tick();
      set_req(0, 1'b0, 32'h0000_3000, 32'h0);
      watch(cyc, pen, pseen, got);
      chk("de_latency", cyc, 1);
      chk("de_no_psel", pseen, 0);
      chk("de_rsp", {rsp_valid, rsp_err}, {4'b0001, 1'b1});
      chk("de_rdata", rsp_rdata, 32'h0);
      drain();

      // randomized traffic
      rate = 30; wait_n = -1;
      repeat (800) tick();
      drain();

      // reset in the middle of ACCESS
      rate = 100; wait_n = 1000;
      for (int c = 0; c < 30 && !penable; c++) tick();
      chk("rm_in_access", penable, 1);
      #1 preset = 1'b1;
      #1 chk("rm_async_clear", {psel, penable}, 64'd0);
      chk("rm_no_rsp", rsp_valid, 64'd0);
      samp();
      @(posedge pclk); #2 preset = 1'b0;
      samp();
      chk("rm_next_grant", req_ready, 4'b0001);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
